// File: rtl/div_ratio_sched.sv
// Round-robin ratio scheduler for a shared programmable clock divider.
// New ratios are applied only at a divider period boundary, so div_clk never produces a runt pulse.
module div_ratio_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int DEF_DIV = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       div_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     err,
  output logic                     busy,
  output logic [DW-1:0]            cur_div,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     div_clk,
  output logic                     div_tick
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t            state;
  logic [DW-1:0]     cnt;
  logic [DW-1:0]     pend;
  logic              wrap;

  logic [IW-1:0]     win;
  logic [IW-1:0]     cand;
  logic              found;
  logic [DW-1:0]     win_div;
  logic [NREQ-1:0]   win_oh;
  logic [NREQ-1:0]   own_oh;
  int                rr_idx;

  // Last count of the current period; the only edge where a new ratio may be loaded.
  assign wrap = (cnt == cur_div - DW'(1));

  // NOTE: asynchronous active-low reset; every flop gets a defined value here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_clk  <= 1'b0;
      div_tick <= 1'b0;
    end else begin
      cnt      <= wrap ? '0 : cnt + DW'(1);
      div_clk  <= (cnt < (cur_div >> 1));
      div_tick <= wrap;
    end
  end

  // Round-robin search starting just after the last owner.
  // NOTE: combinational logic uses blocking '=' with a default for every variable, so no latch is inferred.
  always_comb begin
    win    = '0;
    cand   = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(owner) + k) % NREQ;
      cand   = IW'(rr_idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_div = div_in[win*DW +: DW];
  assign win_oh  = NREQ'(1) << win;
  assign own_oh  = NREQ'(1) << owner;

  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= IW'(NREQ - 1);
      pend    <= '0;
      cur_div <= DW'(DEF_DIV);
      gnt     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner <= win;
            pend  <= win_div;
            busy  <= 1'b1;
            if (win_div < DW'(2)) begin
              state <= ERR;
              gnt   <= win_oh;
              err   <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req[owner]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            // Divider counter wraps to 0 on this same edge, so the new period starts cleanly.
            cur_div <= pend;
            state   <= DONE;
            gnt     <= own_oh;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ratio_sched.sv
// Randomised scoreboard bench for div_ratio_sched: expected grants are queued at stimulus time,
// and a monitor checks grants plus divided-clock period shape against the ratio in effect.
module tb_div_ratio_sched;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int DEF_DIV = 10;
  localparam int IW      = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  div_in;
  logic [NREQ-1:0]     gnt;
  logic                err;
  logic                busy;
  logic [DW-1:0]       cur_div;
  logic [IW-1:0]       owner;
  logic                div_clk;
  logic                div_tick;

  div_ratio_sched #(.NREQ(NREQ), .DW(DW), .DEF_DIV(DEF_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .div_in   (div_in),
    .gnt      (gnt),
    .err      (err),
    .busy     (busy),
    .cur_div  (cur_div),
    .owner    (owner),
    .div_clk  (div_clk),
    .div_tick (div_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit rej;
    int ratio;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   last_owner;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor: grants, cur_div, divided-clock shape ----------------
  int exp_div  = DEF_DIV;
  bit started  = 1'b0;
  int len      = 0;
  int highs    = 0;
  int rises    = 0;
  bit prev_clk = 1'b0;
  int prev_gnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_div  = DEF_DIV;
      started  = 1'b0;
      len      = 0;
      highs    = 0;
      rises    = 0;
      prev_clk = 1'b0;
      prev_gnt = 0;
    end else begin
      if (!started && div_clk) started = 1'b1;
      if (started) begin
        len++;
        if (div_clk) highs++;
        if (div_clk && !prev_clk) rises++;
      end
      prev_clk = div_clk;
      if (div_tick) begin
        if (started) begin
          check("period_len", len, exp_div);
          check("high_len", highs, exp_div / 2);
          check("rises_per_period", rises, 1);
        end
        len   = 0;
        highs = 0;
        rises = 0;
      end
      if (gnt != '0) begin
        check("gnt_one_cycle", prev_gnt, 0);
        check("gnt_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("gnt_vec", int'(gnt), 1 << e.idx);
          check("err_flag", int'(err), int'(e.rej));
          check("owner", int'(owner), e.idx);
          if (!e.rej) exp_div = e.ratio;
        end
      end else if (err) begin
        check("err_without_gnt", int'(err), 0);
      end
      check("cur_div", int'(cur_div), exp_div);
      prev_gnt = int'(gnt);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_gnt(output int idx, output int cyc);
    int c;
    idx = -1;
    cyc = 0;
    c   = 0;
    while (idx < 0 && c < 200) begin
      @(negedge clk);
      c++;
      if (gnt != '0) begin
        cyc = c;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
      end
    end
    if (idx < 0) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_tick();
    int c;
    bit seen;
    c    = 0;
    seen = 1'b0;
    while (!seen && c < 300) begin
      @(negedge clk);
      c++;
      if (div_tick) seen = 1'b1;
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  task automatic set_ratio(input int i, input int r);
    div_in[i*DW +: DW] = DW'(r);
  endtask

  task automatic push(input int i, input bit rej, input int r);
    exp_t e;
    e.idx   = i;
    e.rej   = rej;
    e.ratio = r;
    sb.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int idx, cyc;
    int ratios[NREQ];
    logic [NREQ-1:0] mask;
    int order[$];

    rst_n      = 1'b0;
    req        = '0;
    div_in     = '0;
    last_owner = NREQ - 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_rise", int'(div_clk), 1);
    check("reset_cur_div", int'(cur_div), DEF_DIV);
    check("reset_gnt", int'(gnt), 0);
    check("reset_err", int'(err), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_owner", int'(owner), NREQ - 1);
    repeat (25) @(negedge clk);

    // Ratio 4 on requester 0, accepted at cnt=3: switch lands after cnt=9.
    wait_tick();
    repeat (3) @(negedge clk);
    set_ratio(0, 4);
    req[0] = 1'b1;
    push(0, 1'b0, 4);
    last_owner = 0;
    wait_gnt(idx, cyc);
    check("boundary_latency", cyc, 7);
    req[0] = 1'b0;
    repeat (12) @(negedge clk);

    // Requesters 1 and 3 held together: alternating grants.
    set_ratio(1, 6);
    set_ratio(3, 3);
    req = 4'b1010;
    push(1, 1'b0, 6);
    push(3, 1'b0, 3);
    push(1, 1'b0, 6);
    push(3, 1'b0, 3);
    last_owner = 3;
    for (int n = 0; n < 4; n++) wait_gnt(idx, cyc);
    req = '0;
    repeat (10) @(negedge clk);

    // Odd ratio 5 via requester 2.
    set_ratio(2, 5);
    req[2] = 1'b1;
    push(2, 1'b0, 5);
    last_owner = 2;
    wait_gnt(idx, cyc);
    req[2] = 1'b0;
    repeat (15) @(negedge clk);

    // Ratio 1 is rejected immediately.
    set_ratio(2, 1);
    req[2] = 1'b1;
    push(2, 1'b1, 0);
    wait_gnt(idx, cyc);
    check("err_latency", cyc, 1);
    req[2] = 1'b0;
    repeat (5) @(negedge clk);

    // Withdrawal during WAIT: no grant, ratio unchanged.
    wait_tick();
    set_ratio(0, 7);
    req[0] = 1'b1;
    last_owner = 0;
    @(negedge clk);
    check("withdraw_busy_high", int'(busy), 1);
    req[0] = 1'b0;
    @(negedge clk);
    check("withdraw_busy_low", int'(busy), 0);
    repeat (15) @(negedge clk);

    // Reset pulsed during WAIT.
    wait_tick();
    set_ratio(0, 9);
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wait_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_div_clk", int'(div_clk), 0);
    check("rst_div_tick", int'(div_tick), 0);
    check("rst_cur_div", int'(cur_div), DEF_DIV);
    check("rst_owner", int'(owner), NREQ - 1);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_owner = NREQ - 1;
    repeat (12) @(negedge clk);

    // Random rounds: a random set of requesters asks at once, each drops after its grant.
    for (int round = 0; round < 25; round++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        ratios[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 13);
        set_ratio(i, ratios[i]);
      end
      order.delete();
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (last_owner + k) % NREQ;
        if (mask[i]) begin
          order.push_back(i);
          push(i, ratios[i] < 2, ratios[i]);
        end
      end
      last_owner = order[order.size() - 1];
      req = mask;
      for (int n = 0; n < order.size(); n++) begin
        wait_gnt(idx, cyc);
        if (idx >= 0) req[idx] = 1'b0;
        else req = '0;
      end
      req = '0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
